// File: rtl/bin2bcd_seq_if.sv
// Port bundle for the iterative binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy/done/bcd/ovf and exposes its FSM state.
interface bin2bcd_seq_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   // Handshake: start is a request that is accepted only on an edge where the
   // converter is idle (busy=0, done=0); requests at any other time are dropped.
   // done is a one-cycle valid for bcd/ovf with no ready; the result then holds
   // until the next done.
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;
   logic [1:0]            state_dbg;

   modport master (
      output start, bin,
      input  busy, done, bcd, ovf, state_dbg
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, ovf, state_dbg
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one iteration per clock,
// registered packed-BCD result with sticky overflow and a one-cycle done strobe.
module bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic          clk,
   input  logic          rst,
   bin2bcd_seq_if.slave  io
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    scratch;
   logic [BW-1:0]    adj;
   logic [BW-1:0]    shifted;
   logic [CW-1:0]    cnt;
   logic             sticky;
   logic             carry;
   logic             last;
   logic [BW-1:0]    bcd_q;
   logic             ovf_q;

   // One double-dabble step: correct every digit, then shift the next binary bit in.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj[BW-2:0], shreg[WIDTH-1]};
      carry   = adj[BW-1];
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (io.start) state_nxt = CONV;
         CONV:    if (last)     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A carry out of the top digit means the running value passed 10^DIGITS-1;
   // the low digits stay correct modulo 10^DIGITS, so it is only remembered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         sticky  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.start) begin
                  shreg   <= io.bin;
                  scratch <= '0;
                  cnt     <= '0;
                  sticky  <= 1'b0;
               end
            end
            CONV: begin
               shreg   <= shreg << 1;
               scratch <= shifted;
               sticky  <= sticky | carry;
               cnt     <= cnt + CW'(1);
               if (last) begin
                  bcd_q <= shifted;
                  ovf_q <= sticky | carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.busy      = (state == CONV);
   assign io.done      = (state == DONE);
   assign io.bcd       = bcd_q;
   assign io.ovf       = ovf_q;
   assign io.state_dbg = state;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Iterative (shift-add-3) binary-to-BCD converter that sits between the free-running counter and the seg_7 digit decoders. It replaces the single-cycle combinational converter when WIDTH grows and the adder chain no longer meets timing. It takes one binary sample per start request, runs one double-dabble iteration per clock, and presents a registered, stable packed-BCD result with a one-cycle done strobe.

## Interface
- WIDTH, 16: binary input width, ≥ 1.
- DIGITS, 5: number of BCD digits produced, ≥ 1.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (state CONV).
- done  output  1  one-cycle strobe; bcd and ovf are valid and new.
- bcd  output  4*DIGITS  packed result; digit i at bits [4i+3:4i], ones in [3:0]; held between conversions.
- ovf  output  1  result exceeded 10^DIGITS − 1; updated with bcd.

## Operation
- Reset values: state IDLE, busy=0, done=0, bcd=0, ovf=0, all internal scratch cleared.
- States:
  - IDLE: start=1 → CONV. Load shift register ← bin, scratch digits ← 0, iteration counter ← 0, sticky overflow ← 0. start=0 → stay in IDLE.
  - CONV: each cycle performs one iteration:
    - every scratch digit ≥ 5 gets +3 (all digits in parallel, 4-bit result);
    - the scratch digits shift left one bit as a 4*DIGITS vector, with the shift register MSB entering bit 0;
    - the shift register shifts left;
    - the bit leaving the top digit is ORed into the sticky overflow;
    - the counter increments.
    - On the iteration where counter = WIDTH−1, bcd ← post-shift scratch, ovf ← sticky OR the outgoing bit, then → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- start is ignored in CONV and DONE; it is neither queued nor counted.
- bin is don't-care except on the accepting edge.
- bcd and ovf change only on the edge entering DONE (or on reset). They hold their value through IDLE and through the whole next conversion.
- When ovf=1, bcd holds the DIGITS low-order decimal digits of bin (value mod 10^DIGITS).
- Every bcd digit is always 0–9.
- Reset asserted at any point aborts the conversion immediately and forces the reset values. The next conversion needs a fresh start after rst deasserts.

## Timing
- Edge E0 accepts start. After E0: busy=1.
- Iterations run on E1 … E_WIDTH.
- After E_WIDTH: busy=0, done=1, bcd/ovf new. After E_WIDTH+1: done=0, state IDLE.
- Latency from start edge to done asserted is WIDTH cycles (16 at defaults).
- Minimum start-to-start spacing is WIDTH+2 cycles. start held high continuously produces a conversion every WIDTH+2 cycles.
- busy and done are never high in the same cycle, and neither is high in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- WIDTH=1: one CONV cycle; done follows 1 cycle after the start edge.

## Test plan
- Defaults, reset then start with bin=0 → done exactly 16 cycles after the start edge, bcd=0x00000, ovf=0, busy high for exactly 16 cycles.
- Defaults, bin=65535 → bcd=0x65535, ovf=0. Then bin=9999 → bcd=0x09999. Then bin=1234 → bcd=0x01234. Between done strobes, bcd holds the previous result.
- start held high for 60 cycles with bin changing every cycle → exactly 3 done strobes, 18 cycles apart. Each result matches bin sampled on its accepting edge. start pulses during busy/done have no effect.
- WIDTH=10, DIGITS=3, bin=1023 → bcd=0x023, ovf=1. Then bin=999 → bcd=0x999, ovf=0.
- Assert rst at iteration 8 of a conversion of 4321 → bcd=0, busy=0, done=0, ovf=0 asynchronously. No done strobe follows. A new start with bin=4321 → bcd=0x04321.
- Random bin sweep (≥1000 values, defaults) → bcd matches the decimal reference and every digit is ≤ 9. A scoreboard checks latency of 16 and the single-cycle done width.
